// File: rtl/store_buffer_pkg.sv
// Shared types and sizing constants for the posted-write store buffer.
package store_buffer_pkg;

    localparam int SB_DEPTH_DEF = 4;
    localparam int SB_AW        = 32;
    localparam int SB_DW        = 32;
    localparam int SB_PTR_W     = $clog2(SB_DEPTH_DEF);
    localparam int SB_CNT_W     = $clog2(SB_DEPTH_DEF + 1);

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
        logic             valid;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// CPU-side and Data_Memory-side signals of the store buffer; suffixes are as seen from the buffer.
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int AW = SB_AW,
    parameter int DW = SB_DW
);
    logic [AW-1:0] cpu_addr_i;
    logic [DW-1:0] cpu_wdata_i;
    logic          cpu_memwrite_i;
    logic          cpu_memread_i;
    logic [DW-1:0] cpu_rdata_o;
    logic          stall_o;
    logic          empty_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_memwrite_o;
    logic          mem_memread_o;
    logic [DW-1:0] mem_rdata_i;

    modport slave (
        input  cpu_addr_i, cpu_wdata_i, cpu_memwrite_i, cpu_memread_i, mem_rdata_i,
        output cpu_rdata_o, stall_o, empty_o, mem_addr_o, mem_wdata_o,
               mem_memwrite_o, mem_memread_o
    );

    modport master (
        output cpu_addr_i, cpu_wdata_i, cpu_memwrite_i, cpu_memread_i, mem_rdata_i,
        input  cpu_rdata_o, stall_o, empty_o, mem_addr_o, mem_wdata_o,
               mem_memwrite_o, mem_memread_o
    );

endinterface

// File: rtl/store_buffer_match.sv
// Youngest-first address match across the queued entries; purely combinational.
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t        entries_i [DEPTH],
    input  logic [PTR_W-1:0] tail_i,
    input  logic [SB_AW-1:0] addr_i,
    output logic             hit_o,
    output logic [PTR_W-1:0] hit_idx_o
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest (tail-DEPTH) to youngest (tail-1) so the youngest match is written last.
    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise a miss would infer a latch.
        hit_o     = 1'b0;
        hit_idx_o = '0;
        idx       = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail_i - PTR_W'(k);
            if (entries_i[idx].valid && (entries_i[idx].addr == addr_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between MEM-stage control and Data_Memory with load forwarding.
// Optional build macro STORE_BUF_COALESCE_EN merges a store into the youngest matching entry.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEF
) (
    input logic           clk_i,
    input logic           rst_i,
    store_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_entry_t        entries_q [DEPTH];
    sb_entry_t        entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             hit;
    logic [PTR_W-1:0] hit_idx;
    logic             is_load, is_store, full, drain, coalesce, stall, alloc;

    store_buffer_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match (
        .entries_i (entries_q),
        .tail_i    (tail_q),
        .addr_i    (bus.cpu_addr_i),
        .hit_o     (hit),
        .hit_idx_o (hit_idx)
    );

    // A raw read request keeps the memory port busy even when it collides with a store.
    always_comb begin
        is_store = bus.cpu_memwrite_i;
        is_load  = bus.cpu_memread_i & ~bus.cpu_memwrite_i;
        full     = (count_q == CNT_W'(DEPTH));
        drain    = ~rst_i & ~bus.cpu_memread_i & (count_q != '0);
`ifdef STORE_BUF_COALESCE_EN
        coalesce = is_store & hit & ~(drain & (hit_idx == head_q));
`else
        coalesce = 1'b0;
`endif
        stall    = is_store & full & ~coalesce;
        alloc    = is_store & ~stall & ~coalesce;
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (drain) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + 1'b1;
        end
        if (alloc) begin
            entries_d[tail_q] = '{addr: bus.cpu_addr_i, data: bus.cpu_wdata_i, valid: 1'b1};
            tail_d            = tail_q + 1'b1;
        end
        if (coalesce) begin
            entries_d[hit_idx].data = bus.cpu_wdata_i;
        end
        count_d = count_q + CNT_W'(alloc) - CNT_W'(drain);
    end

    always_comb begin
        bus.cpu_rdata_o    = '0;
        bus.mem_addr_o     = '0;
        bus.mem_wdata_o    = '0;
        bus.mem_memwrite_o = 1'b0;
        bus.mem_memread_o  = 1'b0;
        if (drain) begin
            bus.mem_memwrite_o = 1'b1;
            bus.mem_addr_o     = entries_q[head_q].addr;
            bus.mem_wdata_o    = entries_q[head_q].data;
        end else if (is_load && !hit) begin
            bus.mem_memread_o = 1'b1;
            bus.mem_addr_o    = bus.cpu_addr_i;
        end
        if (is_load) begin
            bus.cpu_rdata_o = hit ? entries_q[hit_idx].data : bus.mem_rdata_i;
        end
        bus.stall_o = stall;
        bus.empty_o = (count_q == '0);
    end

    // NOTE: state updates use <= so every flop samples the pre-edge values of its _d inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // NOTE: only valid bits are cleared; addr/data of an invalid entry are never observed.
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: Data_Memory model plus a scoreboard of expected memory writes.
module tb_store_buffer;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    int          n_checks = 0;
    int          n_err    = 0;
    wr_t         exp_q [$];
    logic [31:0] mem_model [256];
    bit          mem_init_done = 1'b0;

    store_buffer_if bus ();

    store_buffer #(.DEPTH(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data_Memory: combinational read, write on the rising edge.
    assign bus.mem_rdata_i = mem_model[bus.mem_addr_o[7:0]];

    always @(posedge clk) begin
        if (rst && !mem_init_done) begin
            for (int i = 0; i < 256; i++) begin
                mem_model[i] <= (i == 'h30) ? 32'h55 : 32'h0;
            end
            mem_init_done <= 1'b1;
        end else if (bus.mem_memwrite_o) begin
            mem_model[bus.mem_addr_o[7:0]] <= bus.mem_wdata_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every memory write must be the oldest outstanding expected store.
    always @(negedge clk) begin
        if (bus.mem_memwrite_o) begin
            check("drain_expected", 32'(exp_q.size() != 0), 32'd1);
            check("drain_single_access", 32'(bus.mem_memread_o), 32'd0);
            if (exp_q.size() != 0) begin
                wr_t w;
                w = exp_q.pop_front();
                check("drain_addr", bus.mem_addr_o, w.addr);
                check("drain_data", bus.mem_wdata_o, w.data);
            end
        end
    end

    task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
        bus.cpu_memwrite_i = we;
        bus.cpu_memread_i  = re;
        bus.cpu_addr_i     = a;
        bus.cpu_wdata_i    = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic wait_empty(input string tag, input int budget);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < budget && !bus.empty_o; i++) begin
            tick();
        end
        @(negedge clk);
        check(tag, 32'(bus.empty_o), 32'd1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;

        // 1. reset state
        @(negedge clk);
        check("t1_empty", 32'(bus.empty_o), 32'd1);
        check("t1_stall", 32'(bus.stall_o), 32'd0);
        check("t1_memwrite", 32'(bus.mem_memwrite_o), 32'd0);
        check("t1_memread", 32'(bus.mem_memread_o), 32'd0);
        check("t1_mem_addr", bus.mem_addr_o, 32'h0);
        check("t1_mem_wdata", bus.mem_wdata_o, 32'h0);
        check("t1_rdata", bus.cpu_rdata_o, 32'h0);
        tick();

        // 2. store then forwarded load
        drive(1'b1, 1'b0, 32'h10, 32'hAAAA);
        push(32'h10, 32'hAAAA);
        @(negedge clk);
        check("t2_store_stall", 32'(bus.stall_o), 32'd0);
        tick();
        drive(1'b0, 1'b1, 32'h10, 32'h0);
        @(negedge clk);
        check("t2_fwd_rdata", bus.cpu_rdata_o, 32'hAAAA);
        check("t2_fwd_memread", 32'(bus.mem_memread_o), 32'd0);
        check("t2_not_empty", 32'(bus.empty_o), 32'd0);
        tick();
        wait_empty("t2_drained", 5);

        // 3. fill with read held high, stall on the fifth store, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'h40 + 32'(i), 32'h100 + 32'(i));
            push(32'h40 + 32'(i), 32'h100 + 32'(i));
            @(negedge clk);
            check("t3_fill_stall", 32'(bus.stall_o), 32'd0);
            check("t3_fill_rdata", bus.cpu_rdata_o, 32'h0);
            tick();
        end
        drive(1'b1, 1'b1, 32'h44, 32'h105);
        @(negedge clk);
        check("t3_full_stall", 32'(bus.stall_o), 32'd1);
        check("t3_full_no_write", 32'(bus.mem_memwrite_o), 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'h44, 32'h105);
        @(negedge clk);
        check("t3_stall_during_drain", 32'(bus.stall_o), 32'd1);
        check("t3_drain_started", 32'(bus.mem_memwrite_o), 32'd1);
        tick();
        push(32'h44, 32'h105);
        @(negedge clk);
        check("t3_fifth_accepted", 32'(bus.stall_o), 32'd0);
        tick();
        wait_empty("t3_drained", 10);
        check("t3_mem_43", mem_model[8'h43], 32'h103);
        check("t3_mem_44", mem_model[8'h44], 32'h105);

        // 4. two stores to the same address; youngest forwarded, last value lands in memory
`ifdef STORE_BUF_COALESCE_EN
        push(32'h20, 32'h2);
`else
        push(32'h20, 32'h1);
        push(32'h20, 32'h2);
`endif
        drive(1'b1, 1'b1, 32'h20, 32'h1);
        tick();
        drive(1'b1, 1'b1, 32'h20, 32'h2);
        @(negedge clk);
        check("t4_second_stall", 32'(bus.stall_o), 32'd0);
        tick();
        drive(1'b0, 1'b1, 32'h20, 32'h0);
        @(negedge clk);
        check("t4_fwd_youngest", bus.cpu_rdata_o, 32'h2);
        tick();
        wait_empty("t4_drained", 6);
        check("t4_mem_20", mem_model[8'h20], 32'h2);

        // 5. load miss while entries are queued
        drive(1'b1, 1'b1, 32'h50, 32'h77);
        push(32'h50, 32'h77);
        tick();
        drive(1'b0, 1'b1, 32'h30, 32'h0);
        @(negedge clk);
        check("t5_miss_memread", 32'(bus.mem_memread_o), 32'd1);
        check("t5_miss_rdata", bus.cpu_rdata_o, 32'h55);
        check("t5_miss_memwrite", 32'(bus.mem_memwrite_o), 32'd0);
        check("t5_miss_addr", bus.mem_addr_o, 32'h30);
        tick();
        @(negedge clk);
        check("t5_head_kept", 32'(bus.empty_o), 32'd0);
        tick();
        wait_empty("t5_drained", 5);
        check("t5_mem_50", mem_model[8'h50], 32'h77);

        // 6. reset discards queued stores
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h60 + 32'(i), 32'h200 + 32'(i));
            tick();
        end
        @(negedge clk);
        check("t6_queued", 32'(bus.empty_o), 32'd0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("t6_rst_no_write", 32'(bus.mem_memwrite_o), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_empty", 32'(bus.empty_o), 32'd1);
        check("t6_stall", 32'(bus.stall_o), 32'd0);
        check("t6_no_write", 32'(bus.mem_memwrite_o), 32'd0);
        tick();
        tick();
        check("t6_mem_60", mem_model[8'h60], 32'h0);
        check("sb_all_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
